player_control: RTL and testbench

PLAYER_CONTROL -- requirements
Module: player_control

---
 rtl/player_control_if.sv | 27 ++
 rtl/player_control.sv | 146 ++++++++++++++
 tb/tb_player_control.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/player_control_if.sv
// Button/track-end inputs and transport status outputs of player_control.
// master drives buttons and observes status; slave is the controller itself.
interface player_control_if #(
  parameter int TRACKS = 4
);
  localparam int TRACK_W = $clog2(TRACKS);

  logic               btn_play;
  logic               btn_stop;
  logic               btn_next;
  logic               btn_prev;
  logic               track_end;
  logic               playing;
  logic [1:0]         state;
  logic [TRACK_W-1:0] track;
  logic               track_start;

  modport master (
    output btn_play, btn_stop, btn_next, btn_prev, track_end,
    input  playing, state, track, track_start
  );

  modport slave (
    input  btn_play, btn_stop, btn_next, btn_prev, track_end,
    output playing, state, track, track_start
  );
endinterface

// File: rtl/player_control.sv
// Media player transport controller: four debounced buttons plus track_end drive a
// STOPPED/PLAYING/PAUSED FSM. Optional macro PLAYER_REPEAT_ALL_EN wraps playback at the last track.
module player_control #(
  parameter int TRACKS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  player_control_if.slave    bus
);
  localparam int TRACK_W = $clog2(TRACKS);
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TRACK_W-1:0] TRACK_LAST = TRACK_W'(TRACKS - 1);
  localparam int BTN_STOP = 0;
  localparam int BTN_PLAY = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_PREV = 3;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_PLAYING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_t;

  logic [3:0]         w_raw;
  logic [3:0]         r_level;
  logic [3:0]         r_press;
  logic [CNT_W-1:0]   r_cnt [4];

  state_t             r_state;
  logic               r_playing;
  logic [TRACK_W-1:0] r_track;
  logic               r_track_start;

  logic               w_stop, w_play, w_next, w_prev, w_tend;
  logic [TRACK_W-1:0] w_track_inc, w_track_dec;

  assign w_raw = {bus.btn_prev, bus.btn_next, bus.btn_play, bus.btn_stop};

  // r_level is the debounced level; r_cnt counts consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (w_raw[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i]   <= '0;
          r_level[i] <= w_raw[i];
          r_press[i] <= w_raw[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the highest-priority event of a cycle survives, even if its effect is a no-op.
  assign w_stop = r_press[BTN_STOP];
  assign w_play = r_press[BTN_PLAY] & ~r_press[BTN_STOP];
  assign w_next = r_press[BTN_NEXT] & ~|r_press[BTN_PLAY:BTN_STOP];
  assign w_prev = r_press[BTN_PREV] & ~|r_press[BTN_NEXT:BTN_STOP];
  assign w_tend = bus.track_end & ~|r_press;

  assign w_track_inc = (r_track == TRACK_LAST) ? '0 : r_track + 1'b1;
  assign w_track_dec = (r_track == '0) ? TRACK_LAST : r_track - 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_STOPPED;
      r_playing     <= 1'b0;
      r_track       <= '0;
      r_track_start <= 1'b0;
    end else begin
      r_track_start <= 1'b0;
      case (r_state)
        ST_STOPPED: begin
          if (w_play) begin
            r_state       <= ST_PLAYING;
            r_playing     <= 1'b1;
            r_track_start <= 1'b1;
          end else if (w_next) begin
            r_track <= w_track_inc;
          end else if (w_prev) begin
            r_track <= w_track_dec;
          end
        end
        ST_PLAYING: begin
          if (w_stop) begin
            r_state   <= ST_STOPPED;
            r_playing <= 1'b0;
          end else if (w_play) begin
            r_state   <= ST_PAUSED;
            r_playing <= 1'b0;
          end else if (w_next) begin
            r_track       <= w_track_inc;
            r_track_start <= 1'b1;
          end else if (w_prev) begin
            r_track       <= w_track_dec;
            r_track_start <= 1'b1;
          end else if (w_tend) begin
            if (r_track != TRACK_LAST) begin
              r_track       <= r_track + 1'b1;
              r_track_start <= 1'b1;
            end else begin
`ifdef PLAYER_REPEAT_ALL_EN
              r_track       <= '0;
              r_track_start <= 1'b1;
`else
              r_state   <= ST_STOPPED;
              r_playing <= 1'b0;
              r_track   <= '0;
`endif
            end
          end
        end
        ST_PAUSED: begin
          if (w_stop) begin
            r_state <= ST_STOPPED;
          end else if (w_play) begin
            r_state   <= ST_PLAYING;
            r_playing <= 1'b1;
          end else if (w_next) begin
            r_track <= w_track_inc;
          end else if (w_prev) begin
            r_track <= w_track_dec;
          end
        end
        default: begin
          r_state   <= ST_STOPPED;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = r_state;
  assign bus.playing     = r_playing;
  assign bus.track       = r_track;
  assign bus.track_start = r_track_start;
endmodule

// File: tb/tb_player_control.sv
// Directed bench for player_control: every expected output change (with its cycle stamp)
// is queued by the driver and matched by a monitor whenever the outputs change.
module tb_player_control;
  localparam int TRACKS = 4;
  localparam int TW     = 2;
  localparam int SW     = 2 + 1 + TW + 1;
  localparam int W      = 32 + SW;

  localparam logic [3:0] M_STOP = 4'b0001;
  localparam logic [3:0] M_PLAY = 4'b0010;
  localparam logic [3:0] M_NEXT = 4'b0100;
  localparam logic [3:0] M_PREV = 4'b1000;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] prev_snap;

  player_control_if #(.TRACKS(TRACKS)) bus();

  player_control #(.TRACKS(TRACKS), .DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor / scoreboard
  initial prev_snap = '0;
  always @(negedge clk) begin
    logic [SW-1:0] snap;
    logic [W-1:0]  got_e;
    logic [W-1:0]  exp_e;
    snap = {bus.state, bus.playing, bus.track, bus.track_start};
    if (snap !== prev_snap) begin
      checks++;
      got_e = {32'(cyc), snap};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_change cyc=%0d got state=%b playing=%b track=%0d ts=%b, required no change",
                 cyc, snap[5:4], snap[3], snap[2:1], snap[0]);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL out_change got cyc=%0d state=%b playing=%b track=%0d ts=%b, required cyc=%0d state=%b playing=%b track=%0d ts=%b",
                   cyc, snap[5:4], snap[3], snap[2:1], snap[0],
                   exp_e[W-1:SW], exp_e[5:4], exp_e[3], exp_e[2:1], exp_e[0]);
        end
      end
      prev_snap = snap;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [3:0] m);
    bus.btn_stop = m[0];
    bus.btn_play = m[1];
    bus.btn_next = m[2];
    bus.btn_prev = m[3];
  endtask

  task automatic expect_out(input int ofs, input logic [1:0] st, input logic [TW-1:0] tr,
                            input logic ts);
    exp_q.push_back({32'(cyc + ofs), st, (st == 2'b01), tr, ts});
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    set_btns(m);
    tick(hold);
    set_btns(4'b0000);
    tick(6);
  endtask

  // Press with its expected effect: event registers 4 edges in, FSM reacts on the 5th.
  task automatic act(input logic [3:0] m, input logic [1:0] st, input logic [TW-1:0] tr,
                     input logic pulse);
    expect_out(5, st, tr, pulse);
    if (pulse) expect_out(6, st, tr, 1'b0);
    press(m, 5);
  endtask

  task automatic pulse_end();
    bus.track_end = 1'b1;
    tick(1);
    bus.track_end = 1'b0;
    tick(3);
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act_v, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   int'(bus.state),       0);
    chk({tag, "_playing"}, int'(bus.playing),     0);
    chk({tag, "_track"},   int'(bus.track),       0);
    chk({tag, "_ts"},      int'(bus.track_start), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_btns(4'b0000);
    bus.track_end = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk_reset_outputs("reset0");
    tick(3);
    reset = 1'b1;
    tick(2);

    // 3-cycle glitch is rejected, then a long press gives exactly one start
    set_btns(M_PLAY);
    tick(3);
    set_btns(4'b0000);
    tick(8);
    expect_out(5, 2'b01, 2'd0, 1'b1);
    expect_out(6, 2'b01, 2'd0, 1'b0);
    press(M_PLAY, 10);

    // pause / resume / next while playing / stop keeps track
    act(M_PLAY, 2'b10, 2'd0, 1'b0);
    act(M_PLAY, 2'b01, 2'd0, 1'b0);
    act(M_NEXT, 2'b01, 2'd1, 1'b1);
    act(M_STOP, 2'b00, 2'd1, 1'b0);

    // track wrap in STOPPED
    act(M_PREV, 2'b00, 2'd0, 1'b0);
    act(M_PREV, 2'b00, 2'd3, 1'b0);
    act(M_NEXT, 2'b00, 2'd0, 1'b0);
    act(M_NEXT, 2'b00, 2'd1, 1'b0);

    // next and track_end in the same cycle advance by one only
    act(M_PLAY, 2'b01, 2'd1, 1'b1);
    expect_out(5, 2'b01, 2'd2, 1'b1);
    expect_out(6, 2'b01, 2'd2, 1'b0);
    bus.btn_next = 1'b1;
    tick(4);
    bus.track_end = 1'b1;
    tick(1);
    bus.track_end = 1'b0;
    tick(1);
    bus.btn_next = 1'b0;
    tick(6);

    // stop beats play
    act(M_STOP | M_PLAY, 2'b00, 2'd2, 1'b0);

    // track_end on the last track
    act(M_NEXT, 2'b00, 2'd3, 1'b0);
    act(M_PLAY, 2'b01, 2'd3, 1'b1);
`ifdef PLAYER_REPEAT_ALL_EN
    expect_out(1, 2'b01, 2'd0, 1'b1);
    expect_out(2, 2'b01, 2'd0, 1'b0);
    pulse_end();
    act(M_STOP, 2'b00, 2'd0, 1'b0);
`else
    expect_out(1, 2'b00, 2'd0, 1'b0);
    pulse_end();
    press(M_STOP, 5);
`endif
    pulse_end();

    // a hold with a short release yields only one event
    expect_out(5, 2'b01, 2'd0, 1'b1);
    expect_out(6, 2'b01, 2'd0, 1'b0);
    set_btns(M_PLAY);
    tick(10);
    set_btns(4'b0000);
    tick(2);
    set_btns(M_PLAY);
    tick(10);
    set_btns(4'b0000);
    tick(6);

    // track_end before the last track, then into PAUSED at track 2
    expect_out(1, 2'b01, 2'd1, 1'b1);
    expect_out(2, 2'b01, 2'd1, 1'b0);
    pulse_end();
    act(M_NEXT, 2'b01, 2'd2, 1'b1);
    act(M_PLAY, 2'b10, 2'd2, 1'b0);
    pulse_end();
    act(M_PREV, 2'b10, 2'd1, 1'b0);
    act(M_NEXT, 2'b10, 2'd2, 1'b0);

    // reset mid-press in PAUSED, button held through release
    bus.btn_play = 1'b1;
    tick(2);
    #2;
    reset = 1'b0;
    expect_out(0, 2'b00, 2'd0, 1'b0);
    #1 chk_reset_outputs("reset_mid");
    @(posedge clk);
    #1;
    tick(2);
    reset = 1'b1;
    expect_out(5, 2'b01, 2'd0, 1'b1);
    expect_out(6, 2'b01, 2'd0, 1'b0);
    tick(5);
    bus.btn_play = 1'b0;
    tick(6);

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
